// File: rtl/reg_wb_scoreboard_pkg.sv
// Shared widths, reset levels and grant-source encoding for the writeback
// scoreboard and its arbiter.
package reg_wb_scoreboard_pkg;

   localparam int REG_BUS  = 5;
   localparam int RS_BUS   = 5;
   localparam int XLEN_BUS = 32;

   localparam logic [REG_BUS-1:0] REG_ZERO = '0;

   localparam logic RST_ENABLE  = 1'b1;
   localparam logic RST_DISABLE = 1'b0;

   typedef enum logic {
      GNT_E = 1'b0,
      GNT_M = 1'b1
   } gnt_src_t;

   typedef logic [REG_BUS-1:0] reg_idx_t;

endpackage

// File: rtl/reg_wb_scoreboard_if.sv
// Issue, execute/load writeback and register-file port bundle.
// Handshakes: a transfer happens on a cycle where valid and ready are both 1;
// once valid is raised, the source holds valid and payload stable until ready.
interface reg_wb_scoreboard_if
   import reg_wb_scoreboard_pkg::*;
#(
   parameter int REG_NUM = 32,
   parameter int XLEN    = XLEN_BUS
);

   logic                issue_valid_i;
   logic                issue_ready_o;
   logic [RS_BUS-1:0]   issue_rs1_i;
   logic [RS_BUS-1:0]   issue_rs2_i;
   reg_idx_t            issue_rd_i;
   logic                issue_wen_i;
   logic                issue_is_load_i;

   logic                e_valid_i;
   logic                e_ready_o;
   reg_idx_t            e_rd_i;
   logic [XLEN-1:0]     e_wdata_i;

   logic                m_valid_i;
   logic                m_ready_o;
   reg_idx_t            m_rd_i;
   logic [XLEN-1:0]     m_wdata_i;

   logic                wen_o;
   reg_idx_t            rd_o;
   logic [XLEN-1:0]     wdata_o;
   logic [REG_NUM-1:0]  busy_o;
   logic                err_o;
   gnt_src_t            last_grant;

   modport slave (
      input  issue_valid_i, issue_rs1_i, issue_rs2_i, issue_rd_i,
             issue_wen_i, issue_is_load_i,
      input  e_valid_i, e_rd_i, e_wdata_i,
      input  m_valid_i, m_rd_i, m_wdata_i,
      output issue_ready_o, e_ready_o, m_ready_o,
      output wen_o, rd_o, wdata_o, busy_o, err_o, last_grant
   );

   modport master (
      output issue_valid_i, issue_rs1_i, issue_rs2_i, issue_rd_i,
             issue_wen_i, issue_is_load_i,
      output e_valid_i, e_rd_i, e_wdata_i,
      output m_valid_i, m_rd_i, m_wdata_i,
      input  issue_ready_o, e_ready_o, m_ready_o,
      input  wen_o, rd_o, wdata_o, busy_o, err_o, last_grant
   );

endinterface

// File: rtl/reg_wb_scoreboard_wb_rr_arbiter.sv
// Two-way round-robin arbiter for the register-file write port; on contention
// the source that did not win last time gets the port.
module wb_rr_arbiter
   import reg_wb_scoreboard_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     e_valid,
   input  logic     m_valid,
   output logic     e_ready,
   output logic     m_ready,
   output gnt_src_t last_grant
);

   gnt_src_t last_q;
   gnt_src_t last_d;

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) last_q <= GNT_E;
      else                   last_q <= last_d;
   end

   always_comb begin
      e_ready = 1'b0;
      m_ready = 1'b0;
      last_d  = last_q;
      if (rst == RST_DISABLE) begin
         if (e_valid && (!m_valid || last_q == GNT_M)) begin
            e_ready = 1'b1;
            last_d  = GNT_E;
         end else if (m_valid) begin
            m_ready = 1'b1;
            last_d  = GNT_M;
         end
      end
   end

   assign last_grant = last_q;

endmodule

// File: rtl/reg_wb_scoreboard.sv
// GPR write-port controller: busy scoreboard for RAW/WAW issue stalls,
// outstanding-load cap, and E/M writeback arbitration.
module reg_wb_scoreboard
   import reg_wb_scoreboard_pkg::*;
#(
   parameter int REG_NUM   = 32,
   parameter int XLEN      = XLEN_BUS,
   parameter int MAX_LOADS = 4
)(
   input logic               clk_i,
   input logic               rst_i,
   reg_wb_scoreboard_if.slave bus
);

   localparam int CNT_W = $clog2(MAX_LOADS + 1);

   logic [REG_NUM-1:0] busy_q, busy_d, set_vec, clr_vec;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;

   logic               run, hazard, issue_ready, fire;
   logic               e_ready, m_ready, grant, inc, dec;
   gnt_src_t           last_grant;
   reg_idx_t           gnt_rd;
   logic [XLEN-1:0]    gnt_data;

   assign run = (rst_i == RST_DISABLE);

   wb_rr_arbiter u_arb (
      .clk        (clk_i),
      .rst        (rst_i),
      .e_valid    (bus.e_valid_i),
      .m_valid    (bus.m_valid_i),
      .e_ready    (e_ready),
      .m_ready    (m_ready),
      .last_grant (last_grant)
   );

   assign hazard = busy_q[bus.issue_rs1_i] | busy_q[bus.issue_rs2_i]
                 | (bus.issue_wen_i & busy_q[bus.issue_rd_i])
                 | (bus.issue_is_load_i & (cnt_q == CNT_W'(MAX_LOADS)));
   assign issue_ready = run & ~hazard;
   assign fire        = bus.issue_valid_i & issue_ready;

   assign grant    = e_ready | m_ready;
   assign gnt_rd   = m_ready ? bus.m_rd_i    : bus.e_rd_i;
   assign gnt_data = m_ready ? bus.m_wdata_i : bus.e_wdata_i;

   assign bus.issue_ready_o = issue_ready;
   assign bus.e_ready_o     = e_ready;
   assign bus.m_ready_o     = m_ready;
   assign bus.wen_o         = grant & (gnt_rd != REG_ZERO);
   assign bus.rd_o          = grant ? gnt_rd   : REG_ZERO;
   assign bus.wdata_o       = grant ? gnt_data : '0;
   assign bus.busy_o        = busy_q;
   assign bus.err_o         = err_q;
   assign bus.last_grant    = last_grant;

   // A set/clear collision implies a broken WAW stall; set wins and it is flagged.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (fire && bus.issue_wen_i && bus.issue_rd_i != REG_ZERO)
         set_vec[bus.issue_rd_i] = 1'b1;
      if (bus.wen_o)
         clr_vec[gnt_rd] = 1'b1;
      busy_d    = (busy_q & ~clr_vec) | set_vec;
      busy_d[0] = 1'b0;

      err_d = err_q
            | (bus.wen_o & ~busy_q[gnt_rd])
            | (m_ready & (cnt_q == '0))
            | (|(set_vec & clr_vec));

      inc   = fire & bus.issue_is_load_i;
      dec   = m_ready & (cnt_q != '0);
      cnt_d = cnt_q;
      if (inc && !dec)      cnt_d = cnt_q + CNT_W'(1);
      else if (dec && !inc) cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i == RST_ENABLE) begin
         busy_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

endmodule

// File: tb/tb_reg_wb_scoreboard.sv
// Scenario bench for reg_wb_scoreboard: issue stalls, write-port arbitration,
// load cap, rd=0 handling, sticky error and mid-run reset.
module tb_reg_wb_scoreboard;
   import reg_wb_scoreboard_pkg::*;

   logic clk;
   logic rst;

   int n_vec = 0;
   int n_err = 0;

   logic [36:0] exp_q[$];

   reg_wb_scoreboard_if #(.REG_NUM(32), .XLEN(32)) bus ();

   reg_wb_scoreboard #(.REG_NUM(32), .XLEN(32), .MAX_LOADS(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Writeback monitor: every handshake pops the next predicted write.
   always begin
      logic [36:0] exp;
      @(negedge clk);
      #4;
      if (!rst && ((bus.e_valid_i && bus.e_ready_o) || (bus.m_valid_i && bus.m_ready_o))) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL wb_unexpected got rd=%0d data=%h, required no write", bus.rd_o, bus.wdata_o);
         end else begin
            exp = exp_q.pop_front();
            if ({bus.rd_o, bus.wdata_o} !== exp || bus.wen_o !== (exp[36:32] != 5'd0)) begin
               n_err++;
               $display("FAIL wb_write got rd=%0d data=%h wen=%b, required rd=%0d data=%h wen=%b",
                        bus.rd_o, bus.wdata_o, bus.wen_o, exp[36:32], exp[31:0], exp[36:32] != 5'd0);
            end
         end
      end
   end

   task automatic idle_all();
      bus.issue_valid_i   = 1'b0;
      bus.issue_rs1_i     = '0;
      bus.issue_rs2_i     = '0;
      bus.issue_rd_i      = '0;
      bus.issue_wen_i     = 1'b0;
      bus.issue_is_load_i = 1'b0;
      bus.e_valid_i       = 1'b0;
      bus.e_rd_i          = '0;
      bus.e_wdata_i       = '0;
      bus.m_valid_i       = 1'b0;
      bus.m_rd_i          = '0;
      bus.m_wdata_i       = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_all();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drive_issue(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic wen, input logic ld);
      bus.issue_valid_i   = 1'b1;
      bus.issue_rs1_i     = rs1;
      bus.issue_rs2_i     = rs2;
      bus.issue_rd_i      = rd;
      bus.issue_wen_i     = wen;
      bus.issue_is_load_i = ld;
   endtask

   task automatic drive_e(input logic [4:0] rd, input logic [31:0] data);
      bus.e_valid_i = 1'b1;
      bus.e_rd_i    = rd;
      bus.e_wdata_i = data;
   endtask

   task automatic drive_m(input logic [4:0] rd, input logic [31:0] data);
      bus.m_valid_i = 1'b1;
      bus.m_rd_i    = rd;
      bus.m_wdata_i = data;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      drive_issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
      drive_e(5'd4, 32'h1111_1111);
      drive_m(5'd5, 32'h2222_2222);
      #1;
      n_vec++;
      if ({bus.issue_ready_o, bus.e_ready_o, bus.m_ready_o, bus.wen_o} !== 4'b0000 ||
          bus.rd_o !== 5'd0 || bus.wdata_o !== 32'd0) begin
         n_err++;
         $display("FAIL reset_outputs got rdy=%b%b%b wen=%b rd=%0d data=%h, required all 0",
                  bus.issue_ready_o, bus.e_ready_o, bus.m_ready_o, bus.wen_o, bus.rd_o, bus.wdata_o);
      end
      @(negedge clk);
      rst = 1'b0;
      idle_all();
      #1;
      n_vec++;
      if (bus.busy_o !== 32'd0 || bus.err_o !== 1'b0 || bus.last_grant !== GNT_E) begin
         n_err++;
         $display("FAIL reset_state got busy=%h err=%b last=%0d, required busy=0 err=0 last=E",
                  bus.busy_o, bus.err_o, bus.last_grant);
      end
   endtask

   task automatic test_raw_hazard();
      apply_reset();
      drive_issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
      #1;
      n_vec++;
      if (bus.issue_ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL raw_issue_free got ready=%b, required 1", bus.issue_ready_o);
      end
      @(negedge clk);
      n_vec++;
      if (bus.busy_o[5] !== 1'b1) begin
         n_err++;
         $display("FAIL raw_busy_set got busy=%h, required bit5 set", bus.busy_o);
      end
      drive_issue(5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
      drive_e(5'd5, 32'h0000_1234);
      exp_q.push_back({5'd5, 32'h0000_1234});
      #1;
      n_vec++;
      if (bus.issue_ready_o !== 1'b0 || bus.e_ready_o !== 1'b1 || bus.wen_o !== 1'b1 ||
          bus.rd_o !== 5'd5 || bus.wdata_o !== 32'h1234) begin
         n_err++;
         $display("FAIL raw_stall_write got ready=%b e_rdy=%b wen=%b rd=%0d data=%h, required 0 1 1 5 1234",
                  bus.issue_ready_o, bus.e_ready_o, bus.wen_o, bus.rd_o, bus.wdata_o);
      end
      @(negedge clk);
      bus.e_valid_i = 1'b0;
      #1;
      n_vec++;
      if (bus.busy_o[5] !== 1'b0 || bus.issue_ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL raw_release got busy=%h ready=%b, required bit5 clear ready=1",
                  bus.busy_o, bus.issue_ready_o);
      end
      @(negedge clk);
      idle_all();
      n_vec++;
      if (bus.busy_o !== 32'h0000_0040 || bus.err_o !== 1'b0) begin
         n_err++;
         $display("FAIL raw_final got busy=%h err=%b, required 00000040 0", bus.busy_o, bus.err_o);
      end
   endtask

   task automatic test_arbitration();
      apply_reset();
      drive_issue(5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
      @(negedge clk);
      drive_issue(5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
      @(negedge clk);
      idle_all();
      drive_e(5'd3, 32'hAAAA_0003);
      drive_m(5'd4, 32'hBBBB_0004);
      exp_q.push_back({5'd4, 32'hBBBB_0004});
      exp_q.push_back({5'd3, 32'hAAAA_0003});
      #1;
      n_vec++;
      if (bus.m_ready_o !== 1'b1 || bus.e_ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL arb_first got m_rdy=%b e_rdy=%b, required 1 0", bus.m_ready_o, bus.e_ready_o);
      end
      @(negedge clk);
      bus.m_valid_i = 1'b0;
      #1;
      n_vec++;
      if (bus.e_ready_o !== 1'b1 || bus.m_ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL arb_second got e_rdy=%b m_rdy=%b, required 1 0", bus.e_ready_o, bus.m_ready_o);
      end
      @(negedge clk);
      bus.e_valid_i = 1'b0;
      n_vec++;
      if (bus.busy_o !== 32'd0 || bus.err_o !== 1'b0) begin
         n_err++;
         $display("FAIL arb_final got busy=%h err=%b, required 0 0", bus.busy_o, bus.err_o);
      end
   endtask

   task automatic test_load_cap();
      apply_reset();
      for (int i = 1; i <= 4; i++) begin
         drive_issue(5'd0, 5'd0, 5'(i), 1'b1, 1'b1);
         #1;
         n_vec++;
         if (bus.issue_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL cap_fill%0d got ready=%b, required 1", i, bus.issue_ready_o);
         end
         @(negedge clk);
      end
      drive_issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
      drive_m(5'd1, 32'h0000_00D1);
      exp_q.push_back({5'd1, 32'h0000_00D1});
      #1;
      n_vec++;
      if (bus.issue_ready_o !== 1'b0 || bus.m_ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL cap_full got ready=%b m_rdy=%b, required 0 1", bus.issue_ready_o, bus.m_ready_o);
      end
      @(negedge clk);
      drive_m(5'd2, 32'h0000_00D2);
      exp_q.push_back({5'd2, 32'h0000_00D2});
      #1;
      n_vec++;
      if (bus.issue_ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL cap_issue_with_return got ready=%b, required 1", bus.issue_ready_o);
      end
      @(negedge clk);
      bus.m_valid_i = 1'b0;
      drive_issue(5'd0, 5'd0, 5'd6, 1'b1, 1'b1);
      #1;
      n_vec++;
      if (bus.issue_ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL cap_refill got ready=%b, required 1", bus.issue_ready_o);
      end
      @(negedge clk);
      drive_issue(5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
      #1;
      n_vec++;
      if (bus.issue_ready_o !== 1'b0 || bus.err_o !== 1'b0) begin
         n_err++;
         $display("FAIL cap_full_again got ready=%b err=%b, required 0 0", bus.issue_ready_o, bus.err_o);
      end
      @(negedge clk);
      idle_all();
   endtask

   task automatic test_rd_zero();
      apply_reset();
      drive_issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      #1;
      n_vec++;
      if (bus.issue_ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL zero_issue got ready=%b, required 1", bus.issue_ready_o);
      end
      @(negedge clk);
      idle_all();
      n_vec++;
      if (bus.busy_o !== 32'd0) begin
         n_err++;
         $display("FAIL zero_busy got busy=%h, required 0", bus.busy_o);
      end
      drive_e(5'd0, 32'hCAFE_0000);
      exp_q.push_back({5'd0, 32'hCAFE_0000});
      #1;
      n_vec++;
      if (bus.e_ready_o !== 1'b1 || bus.wen_o !== 1'b0) begin
         n_err++;
         $display("FAIL zero_grant got e_rdy=%b wen=%b, required 1 0", bus.e_ready_o, bus.wen_o);
      end
      @(negedge clk);
      bus.e_valid_i = 1'b0;
      drive_issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
      @(negedge clk);
      idle_all();
      drive_m(5'd0, 32'h0BAD_0000);
      exp_q.push_back({5'd0, 32'h0BAD_0000});
      @(negedge clk);
      bus.m_valid_i = 1'b0;
      n_vec++;
      if (bus.err_o !== 1'b0 || bus.busy_o !== 32'd0) begin
         n_err++;
         $display("FAIL zero_no_err got err=%b busy=%h, required 0 0", bus.err_o, bus.busy_o);
      end
   endtask

   task automatic test_error();
      apply_reset();
      drive_e(5'd7, 32'h0000_0777);
      exp_q.push_back({5'd7, 32'h0000_0777});
      #1;
      n_vec++;
      if (bus.err_o !== 1'b0 || bus.e_ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL err_before got err=%b e_rdy=%b, required 0 1", bus.err_o, bus.e_ready_o);
      end
      @(negedge clk);
      bus.e_valid_i = 1'b0;
      n_vec++;
      if (bus.err_o !== 1'b1) begin
         n_err++;
         $display("FAIL err_not_busy got err=%b, required 1", bus.err_o);
      end
      repeat ($urandom_range(2, 5)) @(negedge clk);
      n_vec++;
      if (bus.err_o !== 1'b1) begin
         n_err++;
         $display("FAIL err_sticky got err=%b, required 1", bus.err_o);
      end
      apply_reset();
      n_vec++;
      if (bus.err_o !== 1'b0) begin
         n_err++;
         $display("FAIL err_cleared got err=%b, required 0", bus.err_o);
      end
      drive_m(5'd0, 32'h0000_0E0E);
      exp_q.push_back({5'd0, 32'h0000_0E0E});
      @(negedge clk);
      bus.m_valid_i = 1'b0;
      n_vec++;
      if (bus.err_o !== 1'b1) begin
         n_err++;
         $display("FAIL err_m_underflow got err=%b, required 1", bus.err_o);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      drive_issue(5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
      @(negedge clk);
      drive_issue(5'd0, 5'd0, 5'd10, 1'b1, 1'b1);
      @(negedge clk);
      drive_issue(5'd0, 5'd0, 5'd11, 1'b1, 1'b1);
      @(negedge clk);
      idle_all();
      n_vec++;
      if (bus.busy_o !== 32'h0000_0E00) begin
         n_err++;
         $display("FAIL mid_busy got busy=%h, required 00000e00", bus.busy_o);
      end
      rst = 1'b1;
      drive_issue(5'd0, 5'd0, 5'd12, 1'b1, 1'b1);
      drive_e(5'd9, 32'h9999_9999);
      drive_m(5'd10, 32'hAAAA_AAAA);
      #1;
      n_vec++;
      if ({bus.issue_ready_o, bus.e_ready_o, bus.m_ready_o, bus.wen_o} !== 4'b0000) begin
         n_err++;
         $display("FAIL mid_rst_ready got rdy=%b%b%b wen=%b, required 0000",
                  bus.issue_ready_o, bus.e_ready_o, bus.m_ready_o, bus.wen_o);
      end
      @(negedge clk);
      n_vec++;
      if (bus.busy_o !== 32'd0) begin
         n_err++;
         $display("FAIL mid_rst_busy got busy=%h, required 0", bus.busy_o);
      end
      rst = 1'b0;
      idle_all();
      for (int i = 0; i < 4; i++) begin
         drive_issue(5'd9, 5'd10, 5'(11 + i), 1'b1, 1'b1);
         #1;
         n_vec++;
         if (bus.issue_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reload%0d got ready=%b, required 1", i, bus.issue_ready_o);
         end
         @(negedge clk);
      end
      drive_issue(5'd0, 5'd0, 5'd20, 1'b1, 1'b1);
      #1;
      n_vec++;
      if (bus.issue_ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL mid_cnt_cap got ready=%b, required 0", bus.issue_ready_o);
      end
      @(negedge clk);
      idle_all();
   endtask

   initial begin
      rst = 1'b1;
      idle_all();
      test_reset();
      test_raw_hazard();
      test_arbitration();
      test_load_cap();
      test_rd_zero();
      test_error();
      test_reset_mid();
      repeat (2) @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL wb_drain got %0d pending writes, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
